// File: rtl/fpga_pkg.sv
// Shared constants and types for the sixteen-node serial bus transmitter.
// Imported by the arbiter and the top level.
package fpga_pkg;

    localparam int NODES   = 16;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 4;
    localparam int CRC_W   = 4;
    localparam int FRAME_W = 77;
    localparam int CNT_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        STOP = 2'd2
    } state_t;

    // Frame layout: start bit, source, destination, payload, CRC.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] dst,
        input logic [DATA_W-1:0] data,
        input logic [CRC_W-1:0]  crc
    );
        return {1'b1, src, dst, data, crc};
    endfunction

endpackage

// File: rtl/fpga_bus_arbiter.sv
// Fixed-priority request encoder: lowest set bit of mod wins.
// Node 1 (bit 0) has the highest priority.
module bus_arbiter
    import fpga_pkg::*;
(
    input  logic [NODES-1:0]  mod,
    output logic              valid,
    output logic [ADDR_W-1:0] grant
);

    // Scan from the top so the lowest set bit is the last to write grant.
    always_comb begin
        valid = |mod;
        grant = '0;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (mod[i]) begin
                grant = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/fpga.sv
// Top level of the shared serial bus: per-node input mux, frame shift
// register, bit counter and transmit FSM driving the registered bus line.
module fpga
    import fpga_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [CRC_W-1:0]  CRC1,
    input  logic [CRC_W-1:0]  CRC2,
    input  logic [CRC_W-1:0]  CRC3,
    input  logic [CRC_W-1:0]  CRC4,
    input  logic [CRC_W-1:0]  CRC5,
    input  logic [CRC_W-1:0]  CRC6,
    input  logic [CRC_W-1:0]  CRC7,
    input  logic [CRC_W-1:0]  CRC8,
    input  logic [CRC_W-1:0]  CRC9,
    input  logic [CRC_W-1:0]  CRC10,
    input  logic [CRC_W-1:0]  CRC11,
    input  logic [CRC_W-1:0]  CRC12,
    input  logic [CRC_W-1:0]  CRC13,
    input  logic [CRC_W-1:0]  CRC14,
    input  logic [CRC_W-1:0]  CRC15,
    input  logic [CRC_W-1:0]  CRC16,
    input  logic [DATA_W-1:0] Data1,
    input  logic [DATA_W-1:0] Data2,
    input  logic [DATA_W-1:0] Data3,
    input  logic [DATA_W-1:0] Data4,
    input  logic [DATA_W-1:0] Data5,
    input  logic [DATA_W-1:0] Data6,
    input  logic [DATA_W-1:0] Data7,
    input  logic [DATA_W-1:0] Data8,
    input  logic [DATA_W-1:0] Data9,
    input  logic [DATA_W-1:0] Data10,
    input  logic [DATA_W-1:0] Data11,
    input  logic [DATA_W-1:0] Data12,
    input  logic [DATA_W-1:0] Data13,
    input  logic [DATA_W-1:0] Data14,
    input  logic [DATA_W-1:0] Data15,
    input  logic [DATA_W-1:0] Data16,
    input  logic [ADDR_W-1:0] receiverAddr1,
    input  logic [ADDR_W-1:0] receiverAddr2,
    input  logic [ADDR_W-1:0] receiverAddr3,
    input  logic [ADDR_W-1:0] receiverAddr4,
    input  logic [ADDR_W-1:0] receiverAddr5,
    input  logic [ADDR_W-1:0] receiverAddr6,
    input  logic [ADDR_W-1:0] receiverAddr7,
    input  logic [ADDR_W-1:0] receiverAddr8,
    input  logic [ADDR_W-1:0] receiverAddr9,
    input  logic [ADDR_W-1:0] receiverAddr10,
    input  logic [ADDR_W-1:0] receiverAddr11,
    input  logic [ADDR_W-1:0] receiverAddr12,
    input  logic [ADDR_W-1:0] receiverAddr13,
    input  logic [ADDR_W-1:0] receiverAddr14,
    input  logic [ADDR_W-1:0] receiverAddr15,
    input  logic [ADDR_W-1:0] receiverAddr16,
    input  logic [NODES-1:0]  mod,
    output logic              bus_show
);

    logic [CRC_W-1:0]   crc_arr  [NODES];
    logic [DATA_W-1:0]  data_arr [NODES];
    logic [ADDR_W-1:0]  addr_arr [NODES];

    logic               valid;
    logic [ADDR_W-1:0]  grant;
    logic [FRAME_W-1:0] frame;

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt;

    assign crc_arr[0]  = CRC1;
    assign crc_arr[1]  = CRC2;
    assign crc_arr[2]  = CRC3;
    assign crc_arr[3]  = CRC4;
    assign crc_arr[4]  = CRC5;
    assign crc_arr[5]  = CRC6;
    assign crc_arr[6]  = CRC7;
    assign crc_arr[7]  = CRC8;
    assign crc_arr[8]  = CRC9;
    assign crc_arr[9]  = CRC10;
    assign crc_arr[10] = CRC11;
    assign crc_arr[11] = CRC12;
    assign crc_arr[12] = CRC13;
    assign crc_arr[13] = CRC14;
    assign crc_arr[14] = CRC15;
    assign crc_arr[15] = CRC16;

    assign data_arr[0]  = Data1;
    assign data_arr[1]  = Data2;
    assign data_arr[2]  = Data3;
    assign data_arr[3]  = Data4;
    assign data_arr[4]  = Data5;
    assign data_arr[5]  = Data6;
    assign data_arr[6]  = Data7;
    assign data_arr[7]  = Data8;
    assign data_arr[8]  = Data9;
    assign data_arr[9]  = Data10;
    assign data_arr[10] = Data11;
    assign data_arr[11] = Data12;
    assign data_arr[12] = Data13;
    assign data_arr[13] = Data14;
    assign data_arr[14] = Data15;
    assign data_arr[15] = Data16;

    assign addr_arr[0]  = receiverAddr1;
    assign addr_arr[1]  = receiverAddr2;
    assign addr_arr[2]  = receiverAddr3;
    assign addr_arr[3]  = receiverAddr4;
    assign addr_arr[4]  = receiverAddr5;
    assign addr_arr[5]  = receiverAddr6;
    assign addr_arr[6]  = receiverAddr7;
    assign addr_arr[7]  = receiverAddr8;
    assign addr_arr[8]  = receiverAddr9;
    assign addr_arr[9]  = receiverAddr10;
    assign addr_arr[10] = receiverAddr11;
    assign addr_arr[11] = receiverAddr12;
    assign addr_arr[12] = receiverAddr13;
    assign addr_arr[13] = receiverAddr14;
    assign addr_arr[14] = receiverAddr15;
    assign addr_arr[15] = receiverAddr16;

    bus_arbiter u_arb (
        .mod   (mod),
        .valid (valid),
        .grant (grant)
    );

    // Source address is the grant index itself (node n sends n-1).
    assign frame = build_frame(grant, addr_arr[grant],
                               data_arr[grant], crc_arr[grant]);

    // Transmit FSM: grant and load in IDLE, shift MSB-first, one gap bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bus_show <= 1'b0;
            cnt      <= '0;
            shreg    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus_show <= 1'b0;
                    if (valid) begin
                        shreg <= frame;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    bus_show <= shreg[FRAME_W-1];
                    shreg    <= {shreg[FRAME_W-2:0], 1'b0};
                    if (cnt == CNT_W'(FRAME_W - 1)) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    bus_show <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus_show <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga.sv
// Directed bench for the serial bus transmitter: reset, single frame,
// priority, mid-frame request change, reset abort and a request sweep.
module tb_fpga;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  crc  [16];
    logic [63:0] data [16];
    logic [3:0]  addr [16];
    logic [15:0] mod  = 16'h0000;
    logic        bus_show;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [76:0] cap;

    localparam logic [76:0] F_NODE1 = {1'b1, 4'h0, 4'h1, 64'h1, 4'h1};
    localparam logic [76:0] F_NODE2 =
        {1'b1, 4'h1, 4'h2, 64'hA5A5_0F0F_1234_5678, 4'h9};
    localparam logic [76:0] F_NODE3 =
        {1'b1, 4'h2, 4'h3, 64'hFFFF_0000_8001_7FFE, 4'h6};

    always #5 clock = ~clock;

    fpga dut (
        .clock(clock), .reset(reset),
        .CRC1(crc[0]), .CRC2(crc[1]), .CRC3(crc[2]), .CRC4(crc[3]),
        .CRC5(crc[4]), .CRC6(crc[5]), .CRC7(crc[6]), .CRC8(crc[7]),
        .CRC9(crc[8]), .CRC10(crc[9]), .CRC11(crc[10]), .CRC12(crc[11]),
        .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
        .Data1(data[0]), .Data2(data[1]), .Data3(data[2]), .Data4(data[3]),
        .Data5(data[4]), .Data6(data[5]), .Data7(data[6]), .Data8(data[7]),
        .Data9(data[8]), .Data10(data[9]), .Data11(data[10]),
        .Data12(data[11]), .Data13(data[12]), .Data14(data[13]),
        .Data15(data[14]), .Data16(data[15]),
        .receiverAddr1(addr[0]), .receiverAddr2(addr[1]),
        .receiverAddr3(addr[2]), .receiverAddr4(addr[3]),
        .receiverAddr5(addr[4]), .receiverAddr6(addr[5]),
        .receiverAddr7(addr[6]), .receiverAddr8(addr[7]),
        .receiverAddr9(addr[8]), .receiverAddr10(addr[9]),
        .receiverAddr11(addr[10]), .receiverAddr12(addr[11]),
        .receiverAddr13(addr[12]), .receiverAddr14(addr[13]),
        .receiverAddr15(addr[14]), .receiverAddr16(addr[15]),
        .mod(mod),
        .bus_show(bus_show)
    );

    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cap = {cap[75:0], bus_show};
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        mod   = 16'h0000;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        mod   = 16'h0000;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus_show !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_edge: got %b want 0", bus_show);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            n_checks++;
            if (bus_show !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b want 0", i, bus_show);
            end
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        mod = 16'h0001;
        @(negedge clock);
        n_checks++;
        if (bus_show !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant_cycle: got %b want 0", bus_show);
        end
        shift_bits(77);
        n_checks++;
        if (cap !== F_NODE1) begin
            n_fail++;
            $display("FAIL single_frame: got %h want %h", cap, F_NODE1);
        end
        shift_bits(2);
        n_checks++;
        if (cap[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL single_stop_idle: got %b want 00", cap[1:0]);
        end
        shift_bits(77);
        n_checks++;
        if (cap !== F_NODE1) begin
            n_fail++;
            $display("FAIL single_regrant: got %h want %h", cap, F_NODE1);
        end
        mod = 16'h0000;
    endtask

    task automatic test_priority();
        do_reset();
        mod = 16'h0006;
        @(negedge clock);
        mod = 16'h0004;
        shift_bits(77);
        n_checks++;
        if (cap !== F_NODE2) begin
            n_fail++;
            $display("FAIL prio_node2: got %h want %h", cap, F_NODE2);
        end
        shift_bits(2);
        n_checks++;
        if (cap[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_gap: got %b want 00", cap[1:0]);
        end
        shift_bits(77);
        n_checks++;
        if (cap !== F_NODE3) begin
            n_fail++;
            $display("FAIL prio_node3: got %h want %h", cap, F_NODE3);
        end
        mod = 16'h0000;
    endtask

    task automatic test_mid_frame_change();
        do_reset();
        mod = 16'h0001;
        @(negedge clock);
        shift_bits(40);
        mod     = 16'h0002;
        data[0] = 64'hDEAD_BEEF_CAFE_F00D;
        crc[0]  = 4'hF;
        addr[0] = 4'hC;
        shift_bits(37);
        n_checks++;
        if (cap !== F_NODE1) begin
            n_fail++;
            $display("FAIL midchg_node1: got %h want %h", cap, F_NODE1);
        end
        shift_bits(2);
        n_checks++;
        if (cap[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL midchg_gap: got %b want 00", cap[1:0]);
        end
        shift_bits(77);
        n_checks++;
        if (cap !== F_NODE2) begin
            n_fail++;
            $display("FAIL midchg_node2: got %h want %h", cap, F_NODE2);
        end
        mod     = 16'h0000;
        data[0] = 64'h1;
        crc[0]  = 4'h1;
        addr[0] = 4'h1;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        mod = 16'h0001;
        @(negedge clock);
        shift_bits(30);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (bus_show !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_abort cyc %0d: got %b want 0",
                         i, bus_show);
            end
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus_show !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_grant: got %b want 0", bus_show);
        end
        shift_bits(77);
        n_checks++;
        if (cap !== F_NODE1) begin
            n_fail++;
            $display("FAIL rstmid_restart: got %h want %h", cap, F_NODE1);
        end
        mod = 16'h0000;
    endtask

    // Frames start (start bit seen) at sweep cycles 2, 81, 160, 239:
    // node 1 twice, then node 2, then node 3; zero everywhere else.
    task automatic test_sweep();
        int          starts [4];
        logic [76:0] frames [4];
        logic [15:0] mods   [4];
        logic        exp;
        int          errs;
        starts = '{2, 81, 160, 239};
        frames = '{F_NODE1, F_NODE1, F_NODE2, F_NODE3};
        mods   = '{16'h0001, 16'h0002, 16'h0004, 16'h0000};
        errs   = 0;
        do_reset();
        for (int t = 0; t < 336; t++) begin
            if (t != 0) @(negedge clock);
            exp = 1'b0;
            for (int f = 0; f < 4; f++) begin
                if (t >= starts[f] && t <= starts[f] + 76) begin
                    exp = frames[f][76 - (t - starts[f])];
                end
            end
            n_checks++;
            if (bus_show !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 10) begin
                    $display("FAIL sweep cyc %0d: got %b want %b",
                             t, bus_show, exp);
                end
            end
            if (t % 84 == 0) mod = mods[t / 84];
        end
        mod = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            crc[i]  = 4'(i + 5);
            addr[i] = 4'(15 - i);
            data[i] = {32'hC0DE_0000 | 32'(i), 32'h0BAD_F00D};
        end
        data[0] = 64'h1;
        addr[0] = 4'h1;
        crc[0]  = 4'h1;
        data[1] = 64'hA5A5_0F0F_1234_5678;
        addr[1] = 4'h2;
        crc[1]  = 4'h9;
        data[2] = 64'hFFFF_0000_8001_7FFE;
        addr[2] = 4'h3;
        crc[2]  = 4'h6;

        test_reset();
        test_single_frame();
        test_priority();
        test_mid_frame_change();
        test_reset_mid_frame();
        test_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
